// File: rtl/s2_rr_arbiter.sv
// s2_rr_arbiter
//   Four-way round-robin arbiter that owns a shared, registered output mux
//   (an "S2" two-level select). The current owner moves up to BURST beats of
//   its data into the shared register. The grant then passes to the next
//   requester in rotating priority order.
//
// Ports
//   clk        sole clock, rising edge
//   clr        asynchronous active-high reset
//   req[3:0]   request per source
//   D0..D3     data per source, N bits each
//   gnt[3:0]   registered one-hot grant, all-zero when nobody owns the mux
//   A1,B1      select pins driven from sel[1]
//   A0,B0      select pins driven from sel[0]
//   sel[1:0]   registered index of the current or last owner
//   out        registered shared-register contents
//   out_valid  out holds a beat transferred at the previous edge
//   out_src    index of the source that supplied the beat in out
//   busy       high while a grant is active
module s2_rr_arbiter #(
   parameter int N     = 1,
   parameter int BURST = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [3:0]   req,
   input  logic [N-1:0] D0,
   input  logic [N-1:0] D1,
   input  logic [N-1:0] D2,
   input  logic [N-1:0] D3,
   output logic [3:0]   gnt,
   output logic         A1,
   output logic         B1,
   output logic         A0,
   output logic         B0,
   output logic [1:0]   sel,
   output logic [N-1:0] out,
   output logic         out_valid,
   output logic [1:0]   out_src,
   output logic         busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);

   state_t         state_r, state_s;
   logic [3:0]     gnt_r, gnt_s;
   logic [1:0]     sel_r, sel_s;
   logic [N-1:0]   out_r, out_s;
   logic           out_valid_r, out_valid_s;
   logic [1:0]     out_src_r, out_src_s;
   logic [3:0]     cnt_r, cnt_s;
   logic [1:0]     ptr_r, ptr_s;

   logic [1:0]     arb_ptr_s;
   logic [1:0]     win_s;
   logic           beat_s;
   logic           grant_end_s;
   logic [N-1:0]   owner_data_s;

   // First requester found when scanning from p upwards, wrapping mod 4.
   function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      logic [1:0] win;
      found = 1'b0;
      win   = p;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            found = 1'b1;
            win   = idx;
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   // Data of the current owner, selected by the registered sel.
   always_comb begin
      owner_data_s = D0;
      case (sel_r)
         2'd0:    owner_data_s = D0;
         2'd1:    owner_data_s = D1;
         2'd2:    owner_data_s = D2;
         2'd3:    owner_data_s = D3;
         default: owner_data_s = D0;
      endcase
   end

   // Arbitration: in GRANT the pointer used is the one the grant end installs,
   // so the outgoing owner already ranks lowest when the same edge re-arbitrates.
   always_comb begin
      arb_ptr_s = ptr_r;
      if (state_r == GRANT) begin
         arb_ptr_s = sel_r + 2'd1;
      end else begin
         arb_ptr_s = ptr_r;
      end
      win_s       = pick_winner(req, arb_ptr_s);
      beat_s      = (state_r == GRANT) && req[sel_r];
      grant_end_s = (state_r == GRANT) && (!req[sel_r] || (cnt_r == LAST_BEAT));
   end

   // Next-state and next-output logic.
   always_comb begin
      state_s     = state_r;
      gnt_s       = gnt_r;
      sel_s       = sel_r;
      out_s       = out_r;
      out_valid_s = 1'b0;
      out_src_s   = out_src_r;
      cnt_s       = cnt_r;
      ptr_s       = ptr_r;

      case (state_r)
         IDLE: begin
            if (req != 4'b0000) begin
               state_s = GRANT;
               gnt_s   = onehot(win_s);
               sel_s   = win_s;
               cnt_s   = 4'd0;
            end else begin
               gnt_s   = 4'b0000;
            end
         end

         GRANT: begin
            if (beat_s) begin
               out_s       = owner_data_s;
               out_src_s   = sel_r;
               out_valid_s = 1'b1;
               cnt_s       = cnt_r + 4'd1;
            end else begin
               out_valid_s = 1'b0;
            end

            if (grant_end_s) begin
               ptr_s = sel_r + 2'd1;
               cnt_s = 4'd0;
               if (req != 4'b0000) begin
                  // Covers the lone-requester case too: winner == old owner.
                  gnt_s = onehot(win_s);
                  sel_s = win_s;
               end else begin
                  gnt_s   = 4'b0000;
                  state_s = IDLE;
               end
            end else begin
               ptr_s = ptr_r;
            end
         end

         default: begin
            state_s = IDLE;
            gnt_s   = 4'b0000;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // State and output registers; clr aborts any grant in progress.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_r     <= IDLE;
         gnt_r       <= 4'b0000;
         sel_r       <= 2'd0;
         out_r       <= '0;
         out_valid_r <= 1'b0;
         out_src_r   <= 2'd0;
         cnt_r       <= 4'd0;
         ptr_r       <= 2'd0;
      end else begin
         state_r     <= state_s;
         gnt_r       <= gnt_s;
         sel_r       <= sel_s;
         out_r       <= out_s;
         out_valid_r <= out_valid_s;
         out_src_r   <= out_src_s;
         cnt_r       <= cnt_s;
         ptr_r       <= ptr_s;
      end
   end

   assign gnt       = gnt_r;
   assign sel       = sel_r;
   assign A1        = sel_r[1];
   assign B1        = sel_r[1];
   assign A0        = sel_r[0];
   assign B0        = sel_r[0];
   assign out       = out_r;
   assign out_valid = out_valid_r;
   assign out_src   = out_src_r;
   assign busy      = (state_r == GRANT);

endmodule
